// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared encodings for the sequenced shift unit
// Purpose: FSM state encoding plus direction and mode constants used by
//          shift_sequencer and its testbench.
// Ports:   none (package)
package shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic DIR_LEFT   = 1'b0;
    localparam logic DIR_RIGHT  = 1'b1;
    localparam logic MODE_LOGIC = 1'b0;
    localparam logic MODE_ROT   = 1'b1;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-position shift or rotate
// Purpose: moves the operand one bit left or right; logical mode zero-fills,
//          rotate mode wraps the outgoing bit back in at the other end.
// Ports:   i_d       operand
//          i_dir     0 = left, 1 = right
//          i_rot     0 = logical, 1 = rotate
//          o_q       stepped result
//          o_dropped bit that left the word (valid in both modes; the caller
//                    decides whether it counts as lost)
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_dir,
    input  logic             i_rot,
    output logic [WIDTH-1:0] o_q,
    output logic             o_dropped
);

    logic w_fill;

    always_comb begin
        w_fill    = 1'b0;
        o_q       = i_d;
        o_dropped = 1'b0;
        if (i_dir == DIR_LEFT) begin
            o_dropped = i_d[WIDTH-1];
            w_fill    = (i_rot == MODE_ROT) ? i_d[WIDTH-1] : 1'b0;
            o_q       = {i_d[WIDTH-2:0], w_fill};
        end else begin
            o_dropped = i_d[0];
            w_fill    = (i_rot == MODE_ROT) ? i_d[0] : 1'b0;
            o_q       = {w_fill, i_d[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle shift/rotate unit with valid/ready handshake
// Purpose: accepts an operand, amount and direction, performs one
//          single-position step per clock, then holds the result until
//          downstream accepts it. Flags 1-bits lost in logical mode.
// Ports:   clk, rst_n               clock, async active-low reset
//          in_valid/in_ready        request handshake
//          in_data, in_amt          operand and shift amount
//          in_dir, in_rot           direction (0 left) and mode (0 logical)
//          out_valid/out_ready      result handshake
//          out_data, out_lost       result and lost-bit flag
//          busy                     high while SHIFT or HOLD
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    input  logic             in_rot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_lost,
    output logic             busy
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_data;
    logic             r_lost;
    logic [AMT_W-1:0] r_cnt;
    logic             r_dir;
    logic             r_rot;
    logic [WIDTH-1:0] w_step_q;
    logic             w_step_drop;
    logic             w_accept;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_HOLD);
    assign busy      = (r_state != ST_IDLE);
    assign out_data  = r_data;
    assign out_lost  = r_lost;
    assign w_accept  = in_valid && (r_state == ST_IDLE);

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_d       (r_data),
        .i_dir     (r_dir),
        .i_rot     (r_rot),
        .o_q       (w_step_q),
        .o_dropped (w_step_drop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_next = (in_amt == '0) ? ST_HOLD : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The last step happens on the edge that leaves SHIFT.
                if (r_cnt == AMT_W'(1)) begin
                    w_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_lost <= 1'b0;
            r_cnt  <= '0;
            r_dir  <= DIR_LEFT;
            r_rot  <= MODE_LOGIC;
        end else if (w_accept) begin
            r_data <= in_data;
            r_lost <= 1'b0;
            r_cnt  <= in_amt;
            r_dir  <= in_dir;
            r_rot  <= in_rot;
        end else if (r_state == ST_SHIFT) begin
            r_data <= w_step_q;
            // Rotated-out bits come back in, so only logical mode loses data.
            r_lost <= r_lost | (w_step_drop & (r_rot == MODE_LOGIC));
            r_cnt  <= r_cnt - AMT_W'(1);
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer
module tb_shift_sequencer;
    import shift_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [1:0] in_amt;
    logic       in_dir;
    logic       in_rot;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_lost;
    logic       busy;

    int total;
    int bad;

    typedef struct {
        logic [3:0] d;
        logic [1:0] a;
        logic       dr;
        logic       rt;
        logic [3:0] ed;
        logic       el;
    } vec_t;

    vec_t       vt [10];
    logic [4:0] sb_q [$];

    shift_sequencer #(
        .WIDTH (4),
        .AMT_W (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .in_rot    (in_rot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lost  (out_lost),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference step: returns {dropped_and_counted, next_value}.
    function automatic logic [4:0] model_step(input logic [3:0] d, input logic dr, input logic rt);
        logic [3:0] q;
        logic       lost;
        if (dr == DIR_LEFT) begin
            q    = rt ? {d[2:0], d[3]} : {d[2:0], 1'b0};
            lost = rt ? 1'b0 : d[3];
        end else begin
            q    = rt ? {d[0], d[3:1]} : {1'b0, d[3:1]};
            lost = rt ? 1'b0 : d[0];
        end
        return {lost, q};
    endfunction

    // Called at a negedge with the DUT idle. Checks every intermediate value,
    // latency, scoreboard result, then retires the result.
    task automatic do_req(input logic [3:0] d, input logic [1:0] a, input logic dr,
                          input logic rt, input logic [3:0] ed, input logic el);
        logic [3:0] m;
        logic [4:0] st;
        logic [4:0] exp_rec;
        int         n;
        int         shifts;
        bit         seen;
        sb_q.push_back({el, ed});
        chk("pre_in_ready", 32'(in_ready), 32'd1);
        in_data  = d;
        in_amt   = a;
        in_dir   = dr;
        in_rot   = rt;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
        in_amt   = ~a;
        in_dir   = ~dr;
        in_rot   = ~rt;
        m        = d;
        n        = 0;
        shifts   = 0;
        seen     = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (out_valid) begin
                seen = 1;
            end else begin
                shifts++;
                chk("shift_data", 32'(out_data), 32'(m));
                chk("shift_busy", 32'(busy), 32'd1);
                chk("shift_in_ready", 32'(in_ready), 32'd0);
                st = model_step(m, dr, rt);
                m  = st[3:0];
            end
        end
        if (!seen) begin
            chk("out_valid_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", 32'(n), 32'(a) + 32'd1);
            chk("shift_cycles", 32'(shifts), 32'(a));
            chk("model_data", 32'(out_data), 32'(m));
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                exp_rec = sb_q.pop_front();
                chk("out_data", 32'(out_data), 32'(exp_rec[3:0]));
                chk("out_lost", 32'(out_lost), 32'(exp_rec[4]));
            end
            chk("hold_busy", 32'(busy), 32'd1);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk("retire_valid", 32'(out_valid), 32'd0);
            chk("retire_busy", 32'(busy), 32'd0);
            @(negedge clk);
            chk("retire_in_ready", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [3:0] rd;
        logic [1:0] ra;
        logic       rdr;
        logic       rrt;
        logic [4:0] st;
        logic [3:0] md;
        logic       ml;
        logic [3:0] held;

        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_amt    = 2'd0;
        in_dir    = 1'b0;
        in_rot    = 1'b0;
        out_ready = 1'b0;

        vt[0] = '{4'b0010, 2'd0, DIR_LEFT,  MODE_LOGIC, 4'b0010, 1'b0};
        vt[1] = '{4'b1000, 2'd1, DIR_LEFT,  MODE_LOGIC, 4'b0000, 1'b1};
        vt[2] = '{4'b1000, 2'd1, DIR_RIGHT, MODE_LOGIC, 4'b0100, 1'b0};
        vt[3] = '{4'b1111, 2'd2, DIR_RIGHT, MODE_LOGIC, 4'b0011, 1'b1};
        vt[4] = '{4'b1001, 2'd3, DIR_LEFT,  MODE_ROT,   4'b1100, 1'b0};
        vt[5] = '{4'b0110, 2'd3, DIR_RIGHT, MODE_ROT,   4'b1100, 1'b0};
        vt[6] = '{4'b0001, 2'd3, DIR_LEFT,  MODE_LOGIC, 4'b1000, 1'b0};
        vt[7] = '{4'b0110, 2'd3, DIR_RIGHT, MODE_LOGIC, 4'b0000, 1'b1};
        vt[8] = '{4'b1010, 2'd2, DIR_LEFT,  MODE_LOGIC, 4'b1000, 1'b1};
        vt[9] = '{4'b0101, 2'd1, DIR_RIGHT, MODE_ROT,   4'b1010, 1'b0};

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_lost", 32'(out_lost), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            do_req(vt[i].d, vt[i].a, vt[i].dr, vt[i].rt, vt[i].ed, vt[i].el);
        end

        // Random requests, expected result from the reference step model.
        for (int i = 0; i < 12; i++) begin
            rd  = 4'($urandom_range(0, 15));
            ra  = 2'($urandom_range(0, 3));
            rdr = 1'($urandom_range(0, 1));
            rrt = 1'($urandom_range(0, 1));
            md  = rd;
            ml  = 1'b0;
            for (int k = 0; k < int'(ra); k++) begin
                st = model_step(md, rdr, rrt);
                md = st[3:0];
                ml = ml | st[4];
            end
            do_req(rd, ra, rdr, rrt, md, ml);
        end

        // Backpressure: result 0110 held while in_valid pulses are ignored.
        sb_q.push_back({1'b0, 4'b0110});
        in_data  = 4'b0011;
        in_amt   = 2'd1;
        in_dir   = DIR_LEFT;
        in_rot   = MODE_LOGIC;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_valid_initial", 32'(out_valid), 32'd1);
        held = out_data;
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0] ? 1'b0 : 1'b1;
            in_data  = 4'b1111;
            in_amt   = 2'd0;
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_stable", 32'(out_data), 32'(held));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        if (sb_q.size() != 0) begin
            md = sb_q[0][3:0];
            ml = sb_q[0][4];
            void'(sb_q.pop_front());
            chk("bp_data", 32'(out_data), 32'(md));
            chk("bp_lost", 32'(out_lost), 32'(ml));
        end else begin
            chk("bp_sb_empty", 32'd0, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        do_req(4'b0100, 2'd1, DIR_RIGHT, MODE_LOGIC, 4'b0010, 1'b0);

        // Reset in the middle of a shift aborts without a clock edge.
        in_data  = 4'b1111;
        in_amt   = 2'd3;
        in_dir   = DIR_LEFT;
        in_rot   = MODE_LOGIC;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_data", 32'(out_data), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        do_req(4'b0001, 2'd1, DIR_LEFT, MODE_LOGIC, 4'b0010, 1'b0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle shift unit that accepts an operand, a shift amount and a direction over a valid/ready handshake. It performs one single-position shift or rotate per clock, then holds the result until downstream accepts it. It sits upstream of the combinational 4-bit shifter datapath and supplies an area-lean, sequenced alternative to it for the ALU shift path. It also flags whether any 1-bits were lost off the end.

Parameters:
- WIDTH, 4, operand/result width in bits (min 2)
- AMT_W, 2, width of the shift-amount field; amounts 0..2^AMT_W-1

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- in_data  input  WIDTH  operand
- in_amt  input  AMT_W  shift amount
- in_dir  input  1  0 = left, 1 = right
- in_rot  input  1  0 = logical (zero fill), 1 = rotate
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  shifted result
- out_lost  output  1  at least one 1-bit was shifted out (logical mode only)
- busy  output  1  high in SHIFT or HOLD

Behaviour:
- Clocking and reset:
  - One clock domain: clk.
  - rst_n is asynchronous assert, synchronous release, active-low.
  - Reset forces state IDLE, out_data=0, out_lost=0, internal counter=0.
  - Resulting outputs during and after reset: out_valid=0, busy=0, in_ready=1. Upstream must hold in_valid=0 while rst_n is low.
- States: IDLE, SHIFT, HOLD.
  - in_ready = (state==IDLE).
  - out_valid = (state==HOLD).
  - busy = (state!=IDLE).
  - All three are combinational decodes of registered state.
- IDLE:
  - Accept occurs on a rising edge with in_valid & in_ready.
  - On accept, capture in_data into the data register, clear out_lost, and latch dir and rot.
  - Load cnt = in_amt.
  - If in_amt==0, go to HOLD. Otherwise go to SHIFT.
- SHIFT, each edge:
  - Apply one 1-position step to the data register:
    - left logical: {d[W-2:0],0}
    - right logical: {0,d[W-1]:1}
    - left rotate: {d[W-2:0],d[W-1]}
    - right rotate: {d[0],d[W-1:1]}
  - In logical mode, out_lost |= the bit dropped off the end. In rotate mode, out_lost stays 0.
  - cnt decrements by 1. When cnt==1 before the edge, go to HOLD.
- Latency:
  - For an accept at edge E0, out_valid is high in the cycle after edge E0+amt.
  - Examples: amt=0 gives 1 cycle after accept; amt=3 gives 4 cycles.
- HOLD:
  - out_data and out_lost are stable.
  - On an edge with out_ready=1, go to IDLE.
  - There is no same-edge re-accept, so there is one bubble cycle between results.
- Backpressure: out_ready may stay low indefinitely. Data holds, in_ready stays 0, and in_valid is ignored.
- Amounts at or above WIDTH are legal. Logical mode then yields all zeros; rotate wraps modulo WIDTH (it simply iterates).
- in_* inputs are sampled only on the accept edge. Changes to them at other times have no effect.
- Reset mid-operation (SHIFT or HOLD) aborts immediately and asynchronously. Nothing is produced for the aborted request.

Decomposition:
- Shared package shift_pkg:
  - state encoding (IDLE=2'd0, SHIFT=2'd1, HOLD=2'd2)
  - DIR_LEFT=1'b0, DIR_RIGHT=1'b1
  - MODE_LOGIC=1'b0, MODE_ROT=1'b1
- One natural sub-module: shift_step.
  - Combinational, WIDTH-parametric, single-position shift/rotate.
  - Inputs: d, dir, rot. Outputs: q, dropped bit.
  - Instantiated once in the SHIFT datapath.
- The FSM, counter and handshake live in shift_sequencer.

Test Plan:
- Zero-amount pass-through: in_data=0010, amt=00, left logical -> out_valid in the cycle after accept; out_data=0010, out_lost=0; busy high for exactly 1 cycle when out_ready=1.
- Single shift, both directions:
  - 1000, amt=01, left logical -> out_data=0000, out_lost=1.
  - Same operand, right logical -> 0100, out_lost=0.
  - Both arrive 2 cycles after the accept edge.
- Two right shifts, logical: 1111, amt=10 -> out_data=0011, out_lost=1; exactly 2 SHIFT cycles observed.
- Rotate, maximum amount: 1001, amt=11, left rotate -> intermediate values 0011, 0110, then out_data=1100, out_lost=0.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while pulsing in_valid -> out_valid stays 1, out_data is stable, in_ready=0, no capture occurs. Then raise out_ready=1 -> IDLE after 1 edge and the next request is accepted.
- Reset mid-shift: pull rst_n low during SHIFT of 1111, amt=11 -> out_valid=0, busy=0, out_data=0000 immediately, without waiting for a clock edge. After release, a new 0001, amt=01, left logical request returns 0010.
